game_session_ctrl: RTL
======================

// Module: game_session_ctrl
// PURPOSE
//  Parametrised successor of the single-game controller in the access-control path.
//  Sits between the authentication FSM and the timer/score datapath.
//  Gates NUM_PLAYERS player load inputs and drives the countdown-timer reconfig/enable.
//  Adds over the previous generation: pause/resume, multi-round matches, one-cycle
//  logout/pass-reset pulses, and an idle-level mask for the blocked player inputs.
// PARAMETERS
//  NUM_PLAYERS   2     number of player load channels (1..8)
//  IDLE_MASK     2'b10 p_load_out value while players are blocked (bit i = player i)
//  WAIT_CYCLES   4     cycles spent in WAIT before enable is sampled (>=1)
//  MAX_ROUNDS    3     rounds per match (1..15); match_over asserts after the last round
// PORTS
//  clk           in   1            system clock, all logic on rising edge
//  rst           in   1            asynchronous, active-low reset
//  enable        in   1            level; high = user authenticated
//  start_btn     in   1            level; game start / pause toggle, rising-edge detected
//  logout_btn    in   1            level; request logout
//  pass_rst_btn  in   1            level; request password reset
//  p_load_in     in   NUM_PLAYERS  raw player load inputs
//  time_out      in   1            level; countdown reached zero
//  p_load_out    out  NUM_PLAYERS  gated player loads
//  timer_reconfig out 1            one-cycle pulse; reload the timer
//  timer_enable  out  1            countdown running
//  score_enable  out  1            score display shown on the mux
//  logout_s      out  1            one-cycle pulse on logout
//  pass_reset    out  1            one-cycle pulse on password reset
//  round_cnt     out  4            completed rounds in the current match
//  match_over    out  1            high in GAMEOVER once round_cnt == MAX_ROUNDS
// BEHAVIOUR
//  Reset values: state=WAIT, p_load_out=IDLE_MASK, all other outputs 0, wait counter 0, start edge register 0.
//  start_rise = start_btn & ~start_q, where start_q is start_btn registered.
//  Request priority in every state that accepts requests: logout > pass_rst > start_rise.
//  WAIT:     increment the wait counter until it reaches WAIT_CYCLES-1.
//            Then, if enable=1, go to RECONFIG; otherwise hold.
//  RECONFIG: timer_reconfig=1 for exactly this cycle.
//            Clear score_enable and the wait counter, then go to PREGAME.
//            If match_over was set, also clear round_cnt and match_over.
//  PREGAME:  players blocked.
//            logout: logout_s=1 for one cycle, go to WAIT.
//            pass_rst: pass_reset=1 for one cycle, go to WAIT.
//            start_rise: timer_enable=1, go to PLAY.
//  PLAY:     p_load_out <= p_load_in, a registered one-cycle pass-through.
//            time_out=1 has priority over start_rise in the same cycle:
//              go to GAMEOVER and round_cnt += 1, saturating at MAX_ROUNDS.
//            start_rise alone: timer_enable=0, p_load_out=IDLE_MASK, go to PAUSED.
//            logout/pass_rst are ignored in PLAY.
//  PAUSED:   players blocked, timer stopped.
//            start_rise: timer_enable=1, go to PLAY.
//            logout/pass_rst: pulse as in PREGAME and go to WAIT.
//  GAMEOVER: p_load_out=IDLE_MASK, timer_enable=0, score_enable=1.
//            match_over=1 iff round_cnt==MAX_ROUNDS.
//            logout/pass_rst: pulse and go to WAIT.
//            start_rise: go to WAIT; RECONFIG then handles the match reset.
//  Leaving to WAIT forces p_load_out=IDLE_MASK and timer_enable=0; score_enable keeps its value until RECONFIG.
//  Pulses: logout_s/pass_reset are 0 on every cycle other than the cycle after a request is accepted.
//  Illegal state encodings: go to WAIT with reset values.
//  Async reset mid-game: all outputs return to reset values immediately, without waiting for clk.
// STRUCTURE
//  Shared package game_pkg: state localparams (WAIT, RECONFIG, PREGAME, PLAY, PAUSED,
//  GAMEOVER, 3-bit encoding) and ROUND_W=4, shared with the timer/score blocks.
//  Sub-module btn_edge: 1-bit rising-edge detector with async active-low reset, used for start_btn.
//  Everything else lives in one FSM always block plus the round counter.
// TESTING
//  1. Hold rst=0, then release, enable=1 -> after WAIT_CYCLES+1 cycles a single timer_reconfig pulse; state PREGAME; p_load_out=2'b10.
//  2. PREGAME, pulse start_btn -> timer_enable=1; p_load_in=2'b01 appears on p_load_out one cycle later; time_out=1 -> score_enable=1, round_cnt=1.
//  3. PLAY, start_btn pulse -> PAUSED; timer_enable=0; p_load_out=IDLE_MASK; second pulse -> PLAY resumes; holding start_btn high gives no repeat toggle.
//  4. PREGAME, logout_btn and pass_rst_btn high together -> only logout_s pulses, for exactly 1 cycle; back in WAIT; enable=0 holds the FSM in WAIT.
//  5. Play 3 rounds (MAX_ROUNDS=3) -> match_over=1 in GAMEOVER; start -> RECONFIG clears round_cnt=0 and match_over=0.
//  6. PLAY, time_out and start_rise in the same cycle -> GAMEOVER (not PAUSED); async rst pulse mid-PLAY -> outputs reset without a clk edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encoding and round-count width for the session controller and the timer/score blocks.
// Combinational helpers only: no latency, no flow control.
package game_pkg;

  localparam int ROUND_W = 4;

  typedef enum logic [2:0] {
    ST_WAIT     = 3'd0,
    ST_RECONFIG = 3'd1,
    ST_PREGAME  = 3'd2,
    ST_PLAY     = 3'd3,
    ST_PAUSED   = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

  function automatic logic [ROUND_W-1:0] round_inc(input logic [ROUND_W-1:0] cnt,
                                                   input logic [ROUND_W-1:0] max_cnt);
    return (cnt >= max_cnt) ? max_cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a level button input; rise is combinational from btn and one flop.
// No backpressure: rise is high for the single cycle where btn is high and was low the cycle before.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_d;
  logic btn_q;

  assign btn_d = btn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_q <= 1'b0;
    else      btn_q <= btn_d;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Session controller gating player loads and driving timer reconfig/enable; all outputs registered (1 cycle).
// No backpressure: requests are sampled each cycle, priority logout > pass reset > start edge.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int                     NUM_PLAYERS = 2,
  parameter logic [NUM_PLAYERS-1:0] IDLE_MASK   = 2'b10,
  parameter int                     WAIT_CYCLES = 4,
  parameter int                     MAX_ROUNDS  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   start_btn,
  input  logic                   logout_btn,
  input  logic                   pass_rst_btn,
  input  logic [NUM_PLAYERS-1:0] p_load_in,
  input  logic                   time_out,
  output logic [NUM_PLAYERS-1:0] p_load_out,
  output logic                   timer_reconfig,
  output logic                   timer_enable,
  output logic                   score_enable,
  output logic                   logout_s,
  output logic                   pass_reset,
  output logic [ROUND_W-1:0]     round_cnt,
  output logic                   match_over
);

  localparam int                 WCW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0]     WAIT_LAST = WCW'(WAIT_CYCLES - 1);
  localparam logic [ROUND_W-1:0] MAX_R     = ROUND_W'(MAX_ROUNDS);

  state_t                   state_q, state_d;
  logic [WCW-1:0]           wait_cnt_q, wait_cnt_d;
  logic [NUM_PLAYERS-1:0]   p_load_q, p_load_d;
  logic                     reconfig_q, reconfig_d;
  logic                     timer_en_q, timer_en_d;
  logic                     score_en_q, score_en_d;
  logic                     logout_q, logout_d;
  logic                     pass_reset_q, pass_reset_d;
  logic [ROUND_W-1:0]       round_q, round_d;
  logic                     match_over_q, match_over_d;
  logic                     start_rise;
  logic                     to_wait;

  btn_edge u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (start_btn),
    .rise (start_rise)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    p_load_d     = p_load_q;
    reconfig_d   = 1'b0;
    timer_en_d   = timer_en_q;
    score_en_d   = score_en_q;
    logout_d     = 1'b0;
    pass_reset_d = 1'b0;
    round_d      = round_q;
    match_over_d = match_over_q;
    to_wait      = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q != WAIT_LAST) wait_cnt_d = wait_cnt_q + 1'b1;
        else if (enable)             state_d    = ST_RECONFIG;
      end
      ST_RECONFIG: begin
        reconfig_d = 1'b1;
        score_en_d = 1'b0;
        wait_cnt_d = '0;
        if (match_over_q) begin
          round_d      = '0;
          match_over_d = 1'b0;
        end
        state_d = ST_PREGAME;
      end
      ST_PREGAME, ST_PAUSED: begin
        p_load_d = IDLE_MASK;
        if (state_q == ST_PAUSED) timer_en_d = 1'b0;
        if (logout_btn) begin
          logout_d = 1'b1;
          to_wait  = 1'b1;
        end else if (pass_rst_btn) begin
          pass_reset_d = 1'b1;
          to_wait      = 1'b1;
        end else if (start_rise) begin
          timer_en_d = 1'b1;
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        p_load_d = p_load_in;
        // Timer expiry wins over a simultaneous pause request.
        if (time_out) begin
          round_d = round_inc(round_q, MAX_R);
          state_d = ST_GAMEOVER;
        end else if (start_rise) begin
          timer_en_d = 1'b0;
          p_load_d   = IDLE_MASK;
          state_d    = ST_PAUSED;
        end
      end
      ST_GAMEOVER: begin
        p_load_d     = IDLE_MASK;
        timer_en_d   = 1'b0;
        score_en_d   = 1'b1;
        match_over_d = (round_q == MAX_R);
        if (logout_btn) begin
          logout_d = 1'b1;
          to_wait  = 1'b1;
        end else if (pass_rst_btn) begin
          pass_reset_d = 1'b1;
          to_wait      = 1'b1;
        end else if (start_rise) begin
          to_wait = 1'b1;
        end
      end
      default: begin
        state_d      = ST_WAIT;
        wait_cnt_d   = '0;
        p_load_d     = IDLE_MASK;
        timer_en_d   = 1'b0;
        score_en_d   = 1'b0;
        round_d      = '0;
        match_over_d = 1'b0;
      end
    endcase

    // score_enable deliberately survives the return to WAIT; RECONFIG clears it.
    if (to_wait) begin
      state_d    = ST_WAIT;
      p_load_d   = IDLE_MASK;
      timer_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_WAIT;
      wait_cnt_q   <= '0;
      p_load_q     <= IDLE_MASK;
      reconfig_q   <= 1'b0;
      timer_en_q   <= 1'b0;
      score_en_q   <= 1'b0;
      logout_q     <= 1'b0;
      pass_reset_q <= 1'b0;
      round_q      <= '0;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      p_load_q     <= p_load_d;
      reconfig_q   <= reconfig_d;
      timer_en_q   <= timer_en_d;
      score_en_q   <= score_en_d;
      logout_q     <= logout_d;
      pass_reset_q <= pass_reset_d;
      round_q      <= round_d;
      match_over_q <= match_over_d;
    end
  end

  assign p_load_out     = p_load_q;
  assign timer_reconfig = reconfig_q;
  assign timer_enable   = timer_en_q;
  assign score_enable   = score_en_q;
  assign logout_s       = logout_q;
  assign pass_reset     = pass_reset_q;
  assign round_cnt      = round_q;
  assign match_over     = match_over_q;

endmodule
